// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer for the MEM stage: writes back a dirty victin
// line, refills the missed line and stalls the pipeline until it is done.
module dcache_miss_ctrl #(
    parameter int   ADDR_W = 32,
    parameter int   IDX_W  = 5,
    parameter int   OFF_W  = 5,
    parameter int   CNT_W  = 16,
    localparam int  TAG_W  = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              hit_i,
    input  logic              dirty_i,
    input  logic [TAG_W-1:0]  victim_tag_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              refill_we_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_RF,
        S_FILL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_refill;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_req_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_refill_nxt;
    logic                w_latch;
    logic                w_access;
    logic                w_miss;
    logic [IDX_W-1:0]    w_idx_in;
    logic [TAG_W-1:0]    w_tag_in;
    logic                w_unused;

    assign w_access = mem_read_i | mem_write_i;
    assign w_miss   = w_access & ~hit_i;
    assign w_idx_in = addr_i[OFF_W +: IDX_W];
    assign w_tag_in = addr_i[ADDR_W-1 -: TAG_W];
    assign w_unused = ^addr_i[OFF_W-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_we_nxt     = r_we;
        w_addr_nxt   = r_addr;
        w_refill_nxt = 1'b0;
        w_latch      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_req_nxt = 1'b0;
                w_we_nxt  = 1'b0;
                if (w_miss) begin
                    w_latch   = 1'b1;
                    w_req_nxt = 1'b1;
                    if (dirty_i) begin
                        w_state_nxt = S_WB;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = {victim_tag_i, w_idx_in, {OFF_W{1'b0}}};
                    end else begin
                        w_state_nxt = S_RF;
                        w_addr_nxt  = {w_tag_in, w_idx_in, {OFF_W{1'b0}}};
                    end
                end
            end
            S_WB: begin
                // Drop the request for one cycle before the refill read.
                if (r_req && mem_ack_i) begin
                    w_state_nxt = S_RF;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = {r_tag, r_idx, {OFF_W{1'b0}}};
                end
            end
            S_RF: begin
                if (!r_req) begin
                    w_req_nxt = 1'b1;
                end else if (mem_ack_i) begin
                    w_state_nxt  = S_FILL;
                    w_req_nxt    = 1'b0;
                    w_refill_nxt = 1'b1;
                end
            end
            S_FILL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_tag    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_refill <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_refill <= w_refill_nxt;
            if (w_latch) begin
                r_idx <= w_idx_in;
                r_tag <= w_tag_in;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign refill_we_o = r_refill;
    assign miss_cnt_o  = r_cnt;
    assign stall_o     = (r_state != S_IDLE) | w_miss;

endmodule
